// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, filters lock, staggers clock enables.
// Define PLL_SEQ_STATS_EN to build the timeout/loss statistics counters.
module pll_lock_sequencer #(
  parameter int         NUM_CLK      = 2,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_FILT    = 1024,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter int         ENABLE_DLY   = 8,
  parameter logic [5:0] ICP_INIT     = 6'd16,
  parameter logic [2:0] LPFRES_INIT  = 3'd2,
  parameter logic [1:0] LPFCAP_INIT  = 2'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               cfg_load,
  input  logic [5:0]         cfg_icpsel,
  input  logic [2:0]         cfg_lpfres,
  input  logic [1:0]         cfg_lpfcap,
  output logic               pll_reset,
  output logic [5:0]         icpsel,
  output logic [2:0]         lpfres,
  output logic [1:0]         lpfcap,
  output logic [NUM_CLK-1:0] enclk,
  output logic               ready,
  output logic [7:0]         timeout_cnt,
  output logic [7:0]         loss_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_WAIT = 3'd1,
    S_FILT = 3'd2,
    S_ENA  = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  // One counter is shared by all states, so size it for the longest interval.
  localparam int MAX_A = (RST_CYCLES > LOCK_FILT) ? RST_CYCLES : LOCK_FILT;
  localparam int MAX_B = (LOCK_TIMEOUT > ENABLE_DLY) ? LOCK_TIMEOUT : ENABLE_DLY;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    en_idx;
  logic          lock_meta;
  logic          lock_s;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RST;
      cnt       <= '0;
      en_idx    <= '0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      pll_reset <= 1'b1;
      enclk     <= '0;
      ready     <= 1'b0;
      icpsel    <= ICP_INIT;
      lpfres    <= LPFRES_INIT;
      lpfcap    <= LPFCAP_INIT;
`ifdef PLL_SEQ_STATS_EN
      timeout_cnt <= '0;
      loss_cnt    <= '0;
`endif
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
`ifdef PLL_SEQ_STATS_EN
      // A loss in RUN is counted even when cfg_load wins the same cycle.
      if (state == S_RUN && !lock_s && loss_cnt != 8'hFF)
        loss_cnt <= loss_cnt + 8'd1;
`endif
      if (cfg_load) begin
        icpsel    <= cfg_icpsel;
        lpfres    <= cfg_lpfres;
        lpfcap    <= cfg_lpfcap;
        state     <= S_RST;
        cnt       <= '0;
        en_idx    <= '0;
        pll_reset <= 1'b1;
        enclk     <= '0;
        ready     <= 1'b0;
      end else begin
        case (state)
          S_RST: begin
            if (cnt == CW'(RST_CYCLES - 1)) begin
              state     <= S_WAIT;
              pll_reset <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_WAIT: begin
            if (lock_s) begin
              state <= S_FILT;
              cnt   <= '0;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
              state     <= S_RST;
              cnt       <= '0;
              pll_reset <= 1'b1;
`ifdef PLL_SEQ_STATS_EN
              if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_FILT: begin
            // A single low sample restarts filtering without touching the PLL.
            if (!lock_s) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else if (cnt == CW'(LOCK_FILT - 1)) begin
              state  <= S_ENA;
              cnt    <= '0;
              enclk  <= NUM_CLK'(1);
              en_idx <= 3'd1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_ENA: begin
            if (!lock_s) begin
              state     <= S_RST;
              cnt       <= '0;
              en_idx    <= '0;
              pll_reset <= 1'b1;
              enclk     <= '0;
              ready     <= 1'b0;
            end else if (enclk[NUM_CLK-1]) begin
              state <= S_RUN;
              ready <= 1'b1;
              cnt   <= '0;
            end else if (cnt == CW'(ENABLE_DLY - 1)) begin
              enclk  <= enclk | (NUM_CLK'(1) << en_idx);
              en_idx <= en_idx + 3'd1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_RUN: begin
            if (!lock_s) begin
              state     <= S_RST;
              cnt       <= '0;
              en_idx    <= '0;
              pll_reset <= 1'b1;
              enclk     <= '0;
              ready     <= 1'b0;
            end
          end
          default: begin
            state     <= S_RST;
            cnt       <= '0;
            en_idx    <= '0;
            pll_reset <= 1'b1;
            enclk     <= '0;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef PLL_SEQ_STATS_EN
  assign timeout_cnt = 8'd0;
  assign loss_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: event scoreboard on the default-width instance,
// plus a 7-output instance for reset during the enable ramp.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_FILT    = 1024;
  localparam int LOCK_TIMEOUT = 64;
  localparam int ENABLE_DLY   = 8;
`ifdef PLL_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset = 1'b1, pll_lock = 1'b0, cfg_load = 1'b0;
  logic [5:0] cfg_icpsel = 6'd0;
  logic [2:0] cfg_lpfres = 3'd0;
  logic [1:0] cfg_lpfcap = 2'd0;
  logic       pll_reset, ready;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic [1:0] enclk;
  logic [7:0] timeout_cnt, loss_cnt;
  logic [2:0] state_dbg;

  logic       reset7 = 1'b1, pll_lock7 = 1'b0, cfg_load7 = 1'b0;
  logic       pll_reset7, ready7;
  logic [5:0] icpsel7;
  logic [2:0] lpfres7;
  logic [1:0] lpfcap7;
  logic [6:0] enclk7;
  logic [7:0] timeout_cnt7, loss_cnt7;
  logic [2:0] state_dbg7;

  pll_lock_sequencer #(
    .NUM_CLK(2), .RST_CYCLES(RST_CYCLES), .LOCK_FILT(LOCK_FILT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .ENABLE_DLY(ENABLE_DLY)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .cfg_load(cfg_load),
    .cfg_icpsel(cfg_icpsel), .cfg_lpfres(cfg_lpfres), .cfg_lpfcap(cfg_lpfcap),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .enclk(enclk), .ready(ready), .timeout_cnt(timeout_cnt), .loss_cnt(loss_cnt),
    .state_dbg(state_dbg)
  );

  pll_lock_sequencer #(
    .NUM_CLK(7), .RST_CYCLES(RST_CYCLES), .LOCK_FILT(4),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .ENABLE_DLY(ENABLE_DLY)
  ) dut7 (
    .clk(clk), .reset(reset7), .pll_lock(pll_lock7), .cfg_load(cfg_load7),
    .cfg_icpsel(cfg_icpsel), .cfg_lpfres(cfg_lpfres), .cfg_lpfcap(cfg_lpfcap),
    .pll_reset(pll_reset7), .icpsel(icpsel7), .lpfres(lpfres7), .lpfcap(lpfcap7),
    .enclk(enclk7), .ready(ready7), .timeout_cnt(timeout_cnt7), .loss_cnt(loss_cnt7),
    .state_dbg(state_dbg7)
  );

  // ---------------- scoreboard ----------------
  // Entry = {kind, value, cycle since t0}; kind 1=pll_reset, 2=enclk, 3=ready.
  logic [31:0] exp_q[$];
  logic [31:0] ev_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t0 = 0;
  logic       prev_rst = 1'b1, prev_rdy = 1'b0;
  logic [1:0] prev_en = 2'b00;

  function automatic logic [7:0] exp_cnt(input int n);
    return STATS ? 8'(n) : 8'd0;
  endfunction

  function automatic void push_exp(input logic [7:0] kind, input logic [7:0] val, input int at);
    exp_q.push_back({kind, val, 16'(at)});
  endfunction

  // Advance to the next falling edge and match any output changes against exp_q.
  task automatic tick();
    logic [31:0] obs, want;
    @(negedge clk);
    if (pll_reset !== prev_rst) ev_q.push_back({8'd1, 7'd0, pll_reset, 16'(cyc - t0)});
    if (enclk !== prev_en)      ev_q.push_back({8'd2, 6'd0, enclk, 16'(cyc - t0)});
    if (ready !== prev_rdy)     ev_q.push_back({8'd3, 7'd0, ready, 16'(cyc - t0)});
    prev_rst = pll_reset;
    prev_en  = enclk;
    prev_rdy = ready;
    while (ev_q.size() > 0) begin
      obs = ev_q.pop_front();
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL scoreboard_event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                   obs[31:24], obs[23:16], obs[15:0], want[31:24], want[23:16], want[15:0]);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; pll_lock = 1'b0; cfg_load = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    t0 = cyc;
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b1;
    repeat (3) tick();
    checks += 9;
    if (pll_reset !== 1'b1)     begin errors++; $display("FAIL reset_pll_reset: got %b, expected 1", pll_reset); end
    if (enclk !== 2'b00)        begin errors++; $display("FAIL reset_enclk: got %b, expected 00", enclk); end
    if (ready !== 1'b0)         begin errors++; $display("FAIL reset_ready: got %b, expected 0", ready); end
    if (icpsel !== 6'd16)       begin errors++; $display("FAIL reset_icpsel: got %0d, expected 16", icpsel); end
    if (lpfres !== 3'd2)        begin errors++; $display("FAIL reset_lpfres: got %0d, expected 2", lpfres); end
    if (lpfcap !== 2'd0)        begin errors++; $display("FAIL reset_lpfcap: got %0d, expected 0", lpfcap); end
    if (timeout_cnt !== 8'd0)   begin errors++; $display("FAIL reset_timeout_cnt: got %0d, expected 0", timeout_cnt); end
    if (loss_cnt !== 8'd0)      begin errors++; $display("FAIL reset_loss_cnt: got %0d, expected 0", loss_cnt); end
    if (state_dbg !== 3'd0)     begin errors++; $display("FAIL reset_state: got %0d, expected 0", state_dbg); end
  endtask

  task automatic test_lock_sequence();
    int n;
    do_reset();
    // lock_s high at edge 12; WAIT at 16, FILT at 17, ENA after LOCK_FILT more.
    push_exp(8'd1, 8'd0, RST_CYCLES);
    push_exp(8'd2, 8'd1, 17 + LOCK_FILT);
    push_exp(8'd2, 8'd3, 17 + LOCK_FILT + ENABLE_DLY);
    push_exp(8'd3, 8'd1, 18 + LOCK_FILT + ENABLE_DLY);
    n = 0;
    while (exp_q.size() > 0 && n < 1200) begin
      tick();
      n++;
      if (cyc - t0 == 10) pll_lock = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL lock_sequence_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (state_dbg !== 3'd4) begin errors++; $display("FAIL lock_sequence_state: got %0d, expected 4", state_dbg); end
  endtask

  task automatic test_run_loss();
    int n;
    t0 = cyc;
    pll_lock = 1'b0;
    push_exp(8'd1, 8'd1, 3);
    push_exp(8'd2, 8'd0, 3);
    push_exp(8'd3, 8'd0, 3);
    push_exp(8'd1, 8'd0, 3 + RST_CYCLES);
    push_exp(8'd2, 8'd1, 4 + RST_CYCLES + LOCK_FILT);
    push_exp(8'd2, 8'd3, 4 + RST_CYCLES + LOCK_FILT + ENABLE_DLY);
    push_exp(8'd3, 8'd1, 5 + RST_CYCLES + LOCK_FILT + ENABLE_DLY);
    n = 0;
    while (exp_q.size() > 0 && n < 1200) begin
      tick();
      n++;
      if (cyc - t0 == 5) pll_lock = 1'b1;
      if (cyc - t0 == 4) begin
        checks++;
        if (loss_cnt !== exp_cnt(1)) begin errors++; $display("FAIL run_loss_cnt: got %0d, expected %0d", loss_cnt, exp_cnt(1)); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL run_loss_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_filt_glitch();
    int n;
    do_reset();
    pll_lock = 1'b1;
    push_exp(8'd1, 8'd0, RST_CYCLES);
    push_exp(8'd2, 8'd1, 519 + LOCK_FILT);
    push_exp(8'd2, 8'd3, 519 + LOCK_FILT + ENABLE_DLY);
    push_exp(8'd3, 8'd1, 520 + LOCK_FILT + ENABLE_DLY);
    n = 0;
    while (exp_q.size() > 0 && n < 1700) begin
      tick();
      n++;
      if (cyc - t0 == 515) pll_lock = 1'b0;
      if (cyc - t0 == 516) pll_lock = 1'b1;
      if (cyc - t0 == 517) begin
        checks++;
        if (state_dbg !== 3'd2) begin errors++; $display("FAIL glitch_still_filt: got %0d, expected 2", state_dbg); end
      end
      if (cyc - t0 == 518) begin
        checks++;
        if (state_dbg !== 3'd1 || pll_reset !== 1'b0) begin
          errors++; $display("FAIL glitch_back_to_wait: got state=%0d pll_reset=%b, expected state=1 pll_reset=0", state_dbg, pll_reset);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL filt_glitch_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_exp(8'd1, 8'd0, RST_CYCLES + k * (RST_CYCLES + LOCK_TIMEOUT));
      push_exp(8'd1, 8'd1, (k + 1) * (RST_CYCLES + LOCK_TIMEOUT));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
      if (cyc - t0 == 81) begin
        checks++;
        if (timeout_cnt !== exp_cnt(1)) begin errors++; $display("FAIL timeout_cnt_1: got %0d, expected %0d", timeout_cnt, exp_cnt(1)); end
      end
      if (cyc - t0 == 161) begin
        checks++;
        if (timeout_cnt !== exp_cnt(2)) begin errors++; $display("FAIL timeout_cnt_2: got %0d, expected %0d", timeout_cnt, exp_cnt(2)); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    checks++;
    if (timeout_cnt !== exp_cnt(3)) begin errors++; $display("FAIL timeout_cnt_3: got %0d, expected %0d", timeout_cnt, exp_cnt(3)); end
  endtask

  task automatic test_cfg_load();
    int n;
    do_reset();
    pll_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 1200) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL cfg_initial_ready: got %b, expected 1", ready); end

    t0 = cyc;
    cfg_load = 1'b1; cfg_icpsel = 6'd40; cfg_lpfres = 3'd5; cfg_lpfcap = 2'd3;
    push_exp(8'd1, 8'd1, 1);
    push_exp(8'd2, 8'd0, 1);
    push_exp(8'd3, 8'd0, 1);
    push_exp(8'd1, 8'd0, 1 + RST_CYCLES);
    push_exp(8'd2, 8'd1, 2 + RST_CYCLES + LOCK_FILT);
    push_exp(8'd2, 8'd3, 2 + RST_CYCLES + LOCK_FILT + ENABLE_DLY);
    push_exp(8'd3, 8'd1, 3 + RST_CYCLES + LOCK_FILT + ENABLE_DLY);
    checks++;
    if (icpsel !== 6'd16) begin errors++; $display("FAIL cfg_icpsel_before: got %0d, expected 16", icpsel); end
    n = 0;
    while (exp_q.size() > 0 && n < 1200) begin
      tick();
      n++;
      if (cyc - t0 == 1) begin
        cfg_load = 1'b0;
        checks++;
        if (icpsel !== 6'd40 || lpfres !== 3'd5 || lpfcap !== 2'd3) begin
          errors++; $display("FAIL cfg_applied: got %0d/%0d/%0d, expected 40/5/3", icpsel, lpfres, lpfcap);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cfg_relock_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end

    // cfg_load lands on the same edge the lost lock is first seen.
    t0 = cyc;
    pll_lock = 1'b0;
    push_exp(8'd1, 8'd1, 3);
    push_exp(8'd2, 8'd0, 3);
    push_exp(8'd3, 8'd0, 3);
    push_exp(8'd1, 8'd0, 3 + RST_CYCLES);
    push_exp(8'd1, 8'd1, 3 + RST_CYCLES + LOCK_TIMEOUT);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
      if (cyc - t0 == 2) begin cfg_load = 1'b1; cfg_icpsel = 6'd7; cfg_lpfres = 3'd1; cfg_lpfcap = 2'd1; end
      if (cyc - t0 == 3) cfg_load = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cfg_loss_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    checks += 3;
    if (icpsel !== 6'd7)          begin errors++; $display("FAIL cfg_loss_icpsel: got %0d, expected 7", icpsel); end
    if (loss_cnt !== exp_cnt(1))    begin errors++; $display("FAIL cfg_loss_cnt: got %0d, expected %0d", loss_cnt, exp_cnt(1)); end
    if (timeout_cnt !== exp_cnt(1)) begin errors++; $display("FAIL cfg_timeout_cnt: got %0d, expected %0d", timeout_cnt, exp_cnt(1)); end
  endtask

  task automatic test_reset_mid_ena();
    int n;
    reset7 = 1'b1; pll_lock7 = 1'b0; cfg_load7 = 1'b0;
    repeat (3) tick();
    t0 = cyc;
    reset7 = 1'b0; pll_lock7 = 1'b1;
    n = 0;
    while (enclk7 == 7'd0 && n < 200) begin
      tick();
      n++;
      if (cyc - t0 == 2) begin cfg_load7 = 1'b1; cfg_icpsel = 6'd33; end
      else cfg_load7 = 1'b0;
    end
    // cfg_load at edge 3 restarts RST: WAIT at 19, FILT at 20, ENA 4 cycles later.
    checks += 2;
    if (enclk7 !== 7'h01) begin errors++; $display("FAIL ena7_first_bit: got %h, expected 01", enclk7); end
    if (cyc - t0 != 24)   begin errors++; $display("FAIL ena7_entry_cycle: got %0d, expected 24", cyc - t0); end
    repeat (ENABLE_DLY) tick();
    checks++;
    if (enclk7 !== 7'h03) begin errors++; $display("FAIL ena7_second_bit: got %h, expected 03", enclk7); end
    repeat (ENABLE_DLY) tick();
    checks += 2;
    if (enclk7 !== 7'h07) begin errors++; $display("FAIL ena7_third_bit: got %h, expected 07", enclk7); end
    if (icpsel7 !== 6'd33) begin errors++; $display("FAIL ena7_icpsel: got %0d, expected 33", icpsel7); end
    reset7 = 1'b1;
    tick();
    checks += 5;
    if (enclk7 !== 7'h00 || ready7 !== 1'b0) begin
      errors++; $display("FAIL reset7_enclk_ready: got %h/%b, expected 00/0", enclk7, ready7);
    end
    if (pll_reset7 !== 1'b1) begin errors++; $display("FAIL reset7_pll_reset: got %b, expected 1", pll_reset7); end
    if (icpsel7 !== 6'd16 || lpfres7 !== 3'd2 || lpfcap7 !== 2'd0) begin
      errors++; $display("FAIL reset7_loop_filter: got %0d/%0d/%0d, expected 16/2/0", icpsel7, lpfres7, lpfcap7);
    end
    if (timeout_cnt7 !== 8'd0 || loss_cnt7 !== 8'd0) begin
      errors++; $display("FAIL reset7_counters: got %0d/%0d, expected 0/0", timeout_cnt7, loss_cnt7);
    end
    if (state_dbg7 !== 3'd0) begin errors++; $display("FAIL reset7_state: got %0d, expected 0", state_dbg7); end
    reset7 = 1'b0; pll_lock7 = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lock_sequence();
    test_run_loss();
    test_filt_glitch();
    test_timeout();
    test_cfg_load();
    test_reset_mid_ena();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter NUM_CLK, default 2, number of gated PLL outputs (1..7).
REQ-002 Parameter RST_CYCLES, default 16, PLL reset pulse width in clk cycles (>=2).
REQ-003 Parameter LOCK_FILT, default 1024, consecutive locked cycles required before enabling outputs (>=1).
REQ-004 Parameter LOCK_TIMEOUT, default 65536, cycles to wait for lock before re-resetting the PLL (>=4).
REQ-005 Parameter ENABLE_DLY, default 8, cycles between successive enclk bit assertions (>=1).
REQ-006 Parameters ICP_INIT, LPFRES_INIT, LPFCAP_INIT, defaults 6'd16, 3'd2, 2'd0, loop-filter values after reset.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 pll_lock  in  1  raw PLL lock, asynchronous to clk.
REQ-010 cfg_load  in  1  one-cycle pulse: apply cfg_* values and relock.
REQ-011 cfg_icpsel  in  6; cfg_lpfres  in  3; cfg_lpfcap  in  2  new loop-filter values, sampled when cfg_load=1.
REQ-012 pll_reset  out  1  drives PLL reset.
REQ-013 icpsel  out  6; lpfres  out  3; lpfcap  out  2  drive PLL dynamic loop-filter inputs.
REQ-014 enclk  out  NUM_CLK  drives PLL per-output clock enables.
REQ-015 ready  out  1  all outputs enabled, lock stable.
REQ-016 timeout_cnt  out  8  saturating count of lock timeouts.
REQ-017 loss_cnt  out  8  saturating count of lock losses in RUN.

Function
REQ-018 pll_lock SHALL pass a 2-flop synchronizer; lock_s denotes its output; all decisions use lock_s.
REQ-019 States: RST, WAIT, FILT, ENA, RUN; all outputs registered.
REQ-020 RST: pll_reset=1, enclk=0, ready=0; after exactly RST_CYCLES cycles go to WAIT.
REQ-021 WAIT: pll_reset=0; lock_s=1 -> FILT; LOCK_TIMEOUT cycles without lock_s -> RST and timeout_cnt+1 (saturate at 255).
REQ-022 FILT: lock_s=1 for LOCK_FILT consecutive cycles -> ENA; any lock_s=0 -> WAIT, filter and timeout counters cleared, no PLL reset.
REQ-023 ENA: enclk[i] SHALL rise ENABLE_DLY*i cycles after ENA entry (enclk[0] on first ENA cycle); bits never deassert in ENA; after enclk[NUM_CLK-1] set, next cycle RUN with ready=1.
REQ-024 ENA or RUN with lock_s=0: next cycle enclk=0, ready=0, state RST; loss_cnt+1 (saturate) only if from RUN.
REQ-025 cfg_load=1 in any state: icpsel/lpfres/lpfcap take cfg_* next cycle, enclk=0, ready=0, state RST with fresh RST_CYCLES count.
REQ-026 cfg_load and lock loss in the same cycle: cfg applied and loss counted, single RST entry.
REQ-027 icpsel/lpfres/lpfcap SHALL change only on reset or cfg_load.

Reset
REQ-028 reset=1: state RST, pll_reset=1, enclk=0, ready=0, icpsel=ICP_INIT, lpfres=LPFRES_INIT, lpfcap=LPFCAP_INIT, counters and synchronizer=0; reset mid-ENA/RUN drops enclk next edge.

Configuration
REQ-029 Macro PLL_SEQ_STATS_EN defined: timeout_cnt and loss_cnt counters implemented per REQ-021/REQ-024.
REQ-030 Macro undefined: counters not built, timeout_cnt and loss_cnt tied to 0; all other behaviour identical.

Verification
REQ-031 Defaults, lock rises 10 cycles after reset release -> pll_reset low at cycle 16, enclk=01 then 11 eight cycles later, ready=1 one cycle after.
REQ-032 Lock never rises, LOCK_TIMEOUT=64 -> pll_reset re-pulses every 16+64 cycles, timeout_cnt 1,2,3 (0 without macro).
REQ-033 Lock glitches low 1 cycle during FILT at count 500 -> FILT restarts, no pll_reset, ready delayed by ~500+ cycles.
REQ-034 Lock drops in RUN -> enclk=00, ready=0 within 3 cycles of pll_lock fall, loss_cnt=1, full relock sequence follows.
REQ-035 cfg_load with cfg_icpsel=6'd40 in RUN -> icpsel=40 next cycle, enclk=0, 16-cycle pll_reset, relock; same-cycle lock loss gives loss_cnt+1 and one reset pulse.
REQ-036 reset asserted mid-ENA with NUM_CLK=7 -> all outputs at reset values next edge.
